hack_run_ctrl: RTL and testbench
================================

HACK_RUN_CTRL -- requirements
Module: hack_run_ctrl

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 15, width of CPU program counter (1..16).
REQ-002 SHALL have parameter NUM_BP, default 4, number of PC breakpoints (1..16).
REQ-003 SHALL have parameter CNT_WIDTH, default 32, width of enabled-cycle counter.
REQ-004 SHALL have parameter START_RUNNING, default 0; 1 = enter RUNNING after reset.
REQ-005 SHALL have ports: clk  in  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have: reset  in  1  synchronous, active-high.
REQ-007 SHALL have: pc  in  PC_WIDTH  address of instruction the CPU executes on its next enabled edge.
REQ-008 SHALL have: cmd_valid  in  1; cmd_ready  out  1; cmd_op  in  3; cmd_idx  in  max(1,clog2(NUM_BP)); cmd_arg  in  16.
REQ-009 SHALL have: cpu_ce  out  1  CPU clock enable; cpu_reset  out  1  CPU synchronous reset.
REQ-010 SHALL have: state  out  2; bp_hit  out  1; bp_hit_idx  out  max(1,clog2(NUM_BP)); cycle_count  out  CNT_WIDTH; steps_left  out  16.

Function
REQ-011 SHALL implement states HALTED=0, RUNNING=1, STEPPING=2, CPURST=3, driven on state.
REQ-012 SHALL accept a command on a cycle with cmd_valid & cmd_ready; cmd_ready = 1 in HALTED/RUNNING/STEPPING, 0 in CPURST.
REQ-013 SHALL decode cmd_op: 0 NOP, 1 RUN, 2 HALT, 3 STEP(cmd_arg = count, 0 treated as 1), 4 SET_BP(cmd_idx, addr = cmd_arg[PC_WIDTH-1:0], enable), 5 CLR_BP(cmd_idx), 6 CPU_RESET, 7 CLR_CNT.
REQ-014 SHALL apply every accepted command's effect from the next cycle; outputs in the accepting cycle follow the current state.
REQ-015 SHALL ignore SET_BP/CLR_BP with cmd_idx >= NUM_BP; RUN in RUNNING and HALT in HALTED are no-ops.
REQ-016 SHALL compute match = any enabled breakpoint address == pc, combinationally; lowest matching index wins.
REQ-017 SHALL hold a skip flag, set on accepted RUN or STEP, cleared after the first cycle with cpu_ce=1; match is suppressed while skip=1 so execution resumes from a breakpoint PC.
REQ-018 SHALL drive cpu_ce = 1 in RUNNING/STEPPING when no unsuppressed match, 1 in CPURST, else 0.
REQ-019 SHALL on unsuppressed match in RUNNING/STEPPING: cpu_ce=0, next state HALTED, bp_hit=1, bp_hit_idx=matching index.
REQ-020 SHALL keep bp_hit/bp_hit_idx sticky until an accepted RUN, STEP or CPU_RESET clears them.
REQ-021 SHALL on STEP load steps_left=count and enter STEPPING; each cpu_ce=1 cycle in STEPPING decrements steps_left; decrement from 1 to 0 moves to HALTED.
REQ-022 SHALL load steps_left=0 on accepted RUN and HALT.
REQ-023 SHALL increment cycle_count on every cycle with cpu_ce=1 outside CPURST, wrapping modulo 2^CNT_WIDTH; CLR_CNT zeroes it next cycle (clear wins over increment).
REQ-024 SHALL on CPU_RESET: spend exactly one cycle in CPURST with cpu_reset=1, cpu_ce=1; zero cycle_count and steps_left; then HALTED; breakpoints retained.
REQ-025 SHALL give breakpoint hit priority over step completion in the same cycle (both halt; bp_hit set).
REQ-026 SHALL, when HALT is accepted in a cycle with an unsuppressed match, halt and also set bp_hit.

Reset
REQ-027 SHALL while reset=1: cpu_reset=1, cpu_ce=0, cmd_ready=0; commands ignored.
REQ-028 SHALL after reset: state HALTED (RUNNING if START_RUNNING=1), all breakpoints disabled, cycle_count=0, steps_left=0, bp_hit=0, bp_hit_idx=0, skip=0.
REQ-029 SHALL abandon any in-progress step or CPURST when reset asserts mid-operation.

Verification
REQ-030 Reset, START_RUNNING=0, RUN, hold pc constant 20 cycles -> cpu_ce=1 from 2nd cycle after accept, cycle_count=20 after 20 enabled cycles.
REQ-031 SET_BP idx 1 addr 0x0010, RUN, pc sweeps 0x000C..0x0010 -> cpu_ce=0 at pc=0x0010, state=HALTED, bp_hit=1, bp_hit_idx=1; then RUN -> one enabled cycle at 0x0010 (skip), pc 0x0011 runs on.
REQ-032 STEP cmd_arg=3 from HALTED -> exactly 3 cpu_ce=1 cycles, steps_left 3,2,1,0, then HALTED; STEP arg=0 -> exactly 1 cycle.
REQ-033 While RUNNING, CPU_RESET -> one cycle cpu_reset=1/cpu_ce=1/cmd_ready=0, cycle_count=0, then HALTED with breakpoint 1 still effective.
REQ-034 CNT_WIDTH=4, run 17 enabled cycles -> cycle_count=1; CLR_CNT accepted while running -> 0 next cycle.
REQ-035 Breakpoints at idx 0 and 2 both = 0x0005, pc=0x0005 while STEPPING with steps_left=1 -> halt, bp_hit_idx=0, cpu_ce=0, steps_left stays 1.

Source files
------------

// File: rtl/hack_run_ctrl.sv
// Run/halt/step controller for a Hack CPU: gates the CPU clock enable, drives its
// reset, and halts on PC breakpoints, step-count exhaustion or host command.
module hack_run_ctrl #(
    parameter int PC_WIDTH      = 15,
    parameter int NUM_BP        = 4,
    parameter int CNT_WIDTH     = 32,
    parameter int START_RUNNING = 0,
    localparam int IDX_W        = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PC_WIDTH-1:0]  pc,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [IDX_W-1:0]     cmd_idx,
    input  logic [15:0]          cmd_arg,
    output logic                 cpu_ce,
    output logic                 cpu_reset,
    output logic [1:0]           state,
    output logic                 bp_hit,
    output logic [IDX_W-1:0]     bp_hit_idx,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [15:0]          steps_left
);

    localparam logic [1:0] ST_HALTED   = 2'd0;
    localparam logic [1:0] ST_RUNNING  = 2'd1;
    localparam logic [1:0] ST_STEPPING = 2'd2;
    localparam logic [1:0] ST_CPURST   = 2'd3;

    localparam logic [2:0] OP_NOP       = 3'd0;
    localparam logic [2:0] OP_RUN       = 3'd1;
    localparam logic [2:0] OP_HALT      = 3'd2;
    localparam logic [2:0] OP_STEP      = 3'd3;
    localparam logic [2:0] OP_SET_BP    = 3'd4;
    localparam logic [2:0] OP_CLR_BP    = 3'd5;
    localparam logic [2:0] OP_CPU_RESET = 3'd6;
    localparam logic [2:0] OP_CLR_CNT   = 3'd7;

    logic [1:0]           state_r,       state_n;
    logic [NUM_BP-1:0]    bp_en_r,       bp_en_n;
    logic [PC_WIDTH-1:0]  bp_addr_r [NUM_BP];
    logic [PC_WIDTH-1:0]  bp_addr_n [NUM_BP];
    logic                 skip_r,        skip_n;
    logic                 bp_hit_r,      bp_hit_n;
    logic [IDX_W-1:0]     bp_hit_idx_r,  bp_hit_idx_n;
    logic [CNT_WIDTH-1:0] cycle_count_r, cycle_count_n;
    logic [15:0]          steps_left_r,  steps_left_n;

    logic                 match_s;
    logic [IDX_W-1:0]     match_idx_s;
    logic                 active_s;
    logic                 halt_match_s;
    logic                 cmd_ready_s;
    logic                 accept_s;
    logic                 cpu_ce_s;
    logic                 idx_ok_s;
    logic [15:0]          step_cnt_s;

    // Breakpoint compare; scanning downward lets the lowest matching index win.
    always_comb begin
        match_s     = 1'b0;
        match_idx_s = {IDX_W{1'b0}};
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_en_r[i] && (bp_addr_r[i] == pc)) begin
                match_s     = 1'b1;
                match_idx_s = IDX_W'(i);
            end else begin
                match_s     = match_s;
            end
        end
    end

    // Handshake, clock-enable and CPU reset generation.
    always_comb begin
        active_s     = (state_r == ST_RUNNING) || (state_r == ST_STEPPING);
        halt_match_s = active_s && match_s && !skip_r;
        cmd_ready_s  = !reset && (state_r != ST_CPURST);
        accept_s     = cmd_valid && cmd_ready_s;
        idx_ok_s     = (int'(cmd_idx) < NUM_BP);
        step_cnt_s   = (cmd_arg == 16'd0) ? 16'd1 : cmd_arg;
        if (reset) begin
            cpu_ce_s = 1'b0;
        end else if (state_r == ST_CPURST) begin
            cpu_ce_s = 1'b1;
        end else if (active_s && !halt_match_s) begin
            cpu_ce_s = 1'b1;
        end else begin
            cpu_ce_s = 1'b0;
        end
    end

    // Next-state: autonomous progress first, then an accepted command overrides.
    always_comb begin
        state_n       = state_r;
        bp_en_n       = bp_en_r;
        bp_addr_n     = bp_addr_r;
        skip_n        = skip_r;
        bp_hit_n      = bp_hit_r;
        bp_hit_idx_n  = bp_hit_idx_r;
        cycle_count_n = cycle_count_r;
        steps_left_n  = steps_left_r;

        case (state_r)
            ST_RUNNING: begin
                if (halt_match_s) begin
                    state_n = ST_HALTED;
                end else begin
                    state_n = ST_RUNNING;
                end
            end
            ST_STEPPING: begin
                if (halt_match_s) begin
                    state_n = ST_HALTED;
                end else if (steps_left_r <= 16'd1) begin
                    state_n      = ST_HALTED;
                    steps_left_n = 16'd0;
                end else begin
                    steps_left_n = steps_left_r - 16'd1;
                end
            end
            ST_CPURST: state_n = ST_HALTED;
            default:   state_n = state_r;
        endcase

        if (halt_match_s) begin
            bp_hit_n     = 1'b1;
            bp_hit_idx_n = match_idx_s;
        end else begin
            bp_hit_n     = bp_hit_r;
        end

        if (cpu_ce_s) begin
            skip_n = 1'b0;
        end else begin
            skip_n = skip_r;
        end

        if (cpu_ce_s && (state_r != ST_CPURST)) begin
            cycle_count_n = cycle_count_r + CNT_WIDTH'(1);
        end else begin
            cycle_count_n = cycle_count_r;
        end

        if (accept_s) begin
            case (cmd_op)
                OP_NOP: state_n = state_n;
                OP_RUN: begin
                    if (state_r != ST_RUNNING) begin
                        state_n      = ST_RUNNING;
                        skip_n       = 1'b1;
                        bp_hit_n     = 1'b0;
                        bp_hit_idx_n = {IDX_W{1'b0}};
                        steps_left_n = 16'd0;
                    end else begin
                        state_n      = state_n;
                    end
                end
                // A breakpoint hit in the same cycle still records bp_hit.
                OP_HALT: begin
                    if (state_r != ST_HALTED) begin
                        state_n      = ST_HALTED;
                        steps_left_n = 16'd0;
                    end else begin
                        state_n      = state_n;
                    end
                end
                OP_STEP: begin
                    state_n      = ST_STEPPING;
                    steps_left_n = step_cnt_s;
                    skip_n       = 1'b1;
                    bp_hit_n     = 1'b0;
                    bp_hit_idx_n = {IDX_W{1'b0}};
                end
                OP_SET_BP: begin
                    if (idx_ok_s) begin
                        bp_en_n[cmd_idx]   = 1'b1;
                        bp_addr_n[cmd_idx] = cmd_arg[PC_WIDTH-1:0];
                    end else begin
                        bp_en_n = bp_en_n;
                    end
                end
                OP_CLR_BP: begin
                    if (idx_ok_s) begin
                        bp_en_n[cmd_idx] = 1'b0;
                    end else begin
                        bp_en_n = bp_en_n;
                    end
                end
                OP_CPU_RESET: begin
                    state_n       = ST_CPURST;
                    cycle_count_n = {CNT_WIDTH{1'b0}};
                    steps_left_n  = 16'd0;
                    bp_hit_n      = 1'b0;
                    bp_hit_idx_n  = {IDX_W{1'b0}};
                end
                OP_CLR_CNT: cycle_count_n = {CNT_WIDTH{1'b0}};
                default:    state_n = state_n;
            endcase
        end else begin
            state_n = state_n;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= (START_RUNNING != 0) ? ST_RUNNING : ST_HALTED;
            bp_en_r       <= {NUM_BP{1'b0}};
            skip_r        <= 1'b0;
            bp_hit_r      <= 1'b0;
            bp_hit_idx_r  <= {IDX_W{1'b0}};
            cycle_count_r <= {CNT_WIDTH{1'b0}};
            steps_left_r  <= 16'd0;
            for (int i = 0; i < NUM_BP; i++) begin
                bp_addr_r[i] <= {PC_WIDTH{1'b0}};
            end
        end else begin
            state_r       <= state_n;
            bp_en_r       <= bp_en_n;
            skip_r        <= skip_n;
            bp_hit_r      <= bp_hit_n;
            bp_hit_idx_r  <= bp_hit_idx_n;
            cycle_count_r <= cycle_count_n;
            steps_left_r  <= steps_left_n;
            for (int i = 0; i < NUM_BP; i++) begin
                bp_addr_r[i] <= bp_addr_n[i];
            end
        end
    end

    assign cmd_ready   = cmd_ready_s;
    assign cpu_ce      = cpu_ce_s;
    assign cpu_reset   = reset || (state_r == ST_CPURST);
    assign state       = state_r;
    assign bp_hit      = bp_hit_r;
    assign bp_hit_idx  = bp_hit_idx_r;
    assign cycle_count = cycle_count_r;
    assign steps_left  = steps_left_r;

endmodule

// File: tb/tb_hack_run_ctrl.sv
// Directed bench for hack_run_ctrl; a second instance with a 4-bit counter
// shares all stimulus to exercise counter wrap.
module tb_hack_run_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] pc;
    logic        cmd_valid;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_idx;
    logic [15:0] cmd_arg;

    logic        cmd_ready, cpu_ce, cpu_reset, bp_hit;
    logic [1:0]  state, bp_hit_idx;
    logic [31:0] cycle_count;
    logic [15:0] steps_left;

    logic        cmd_ready4, cpu_ce4, cpu_reset4, bp_hit4;
    logic [1:0]  state4, bp_hit_idx4;
    logic [3:0]  cycle_count4;
    logic [15:0] steps_left4;

    int passed = 0;
    int total  = 0;

    hack_run_ctrl dut (
        .clk(clk), .reset(reset), .pc(pc),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_idx(cmd_idx), .cmd_arg(cmd_arg),
        .cpu_ce(cpu_ce), .cpu_reset(cpu_reset), .state(state),
        .bp_hit(bp_hit), .bp_hit_idx(bp_hit_idx),
        .cycle_count(cycle_count), .steps_left(steps_left)
    );

    hack_run_ctrl #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .pc(pc),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4), .cmd_op(cmd_op),
        .cmd_idx(cmd_idx), .cmd_arg(cmd_arg),
        .cpu_ce(cpu_ce4), .cpu_reset(cpu_reset4), .state(state4),
        .bp_hit(bp_hit4), .bp_hit_idx(bp_hit_idx4),
        .cycle_count(cycle_count4), .steps_left(steps_left4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cmd(input logic [2:0] op, input logic [1:0] idx, input logic [15:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_idx   = idx;
        cmd_arg   = arg;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; pc = 15'd0;
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_idx = 2'd0; cmd_arg = 16'd0;
        tick(); tick();
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_cpu_ce",    32'(cpu_ce),    32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0; reset = 1'b0;
        tick();
        chk("post_rst_state", 32'(state),       32'd0);
        chk("post_rst_cnt",   cycle_count,      32'd0);
        chk("post_rst_steps", 32'(steps_left),  32'd0);
        chk("post_rst_bphit", 32'(bp_hit),      32'd0);
        chk("post_rst_bpidx", 32'(bp_hit_idx),  32'd0);
        chk("post_rst_cpurst",32'(cpu_reset),   32'd0);
        chk("post_rst_ready", 32'(cmd_ready),   32'd1);

        // free run with a constant PC
        pc = 15'd100;
        cmd_valid = 1'b1; cmd_op = 3'd1; #1;
        chk("run_accept_ce", 32'(cpu_ce), 32'd0);
        tick(); cmd_valid = 1'b0;
        chk("run_state", 32'(state), 32'd1);
        chk("run_ce",    32'(cpu_ce), 32'd1);
        chk("run_cnt0",  cycle_count, 32'd0);
        repeat (20) tick();
        chk("run_cnt20",  cycle_count, 32'd20);
        chk("run_cnt20w", 32'(cycle_count4), 32'd4);
        cmd(3'd2, 2'd0, 16'd0);
        chk("halt_state", 32'(state), 32'd0);
        chk("halt_cnt",   cycle_count, 32'd21);
        chk("halt_ce",    32'(cpu_ce), 32'd0);

        // breakpoint at 0x10 on index 1
        cmd(3'd4, 2'd1, 16'h0010);
        pc = 15'h000C;
        cmd(3'd1, 2'd0, 16'd0);
        tick(); pc = 15'h000D;
        tick(); pc = 15'h000E;
        tick(); pc = 15'h000F;
        tick(); pc = 15'h0010; #1;
        chk("bp_ce_low", 32'(cpu_ce), 32'd0);
        tick();
        chk("bp_state",  32'(state),      32'd0);
        chk("bp_hit",    32'(bp_hit),     32'd1);
        chk("bp_idx",    32'(bp_hit_idx), 32'd1);
        chk("bp_cnt",    cycle_count,     32'd25);
        cmd(3'd1, 2'd0, 16'd0);
        chk("resume_ce",    32'(cpu_ce), 32'd1);
        chk("resume_bphit", 32'(bp_hit), 32'd0);
        chk("resume_state", 32'(state),  32'd1);
        tick(); pc = 15'h0011; #1;
        chk("resume_cnt", cycle_count, 32'd26);
        chk("resume_ce2", 32'(cpu_ce), 32'd1);
        tick();
        chk("resume_cnt2",  cycle_count, 32'd27);
        chk("resume_state2",32'(state),  32'd1);

        // CPU reset from RUNNING
        cmd(3'd6, 2'd0, 16'd0);
        chk("cpurst_state", 32'(state),     32'd3);
        chk("cpurst_rst",   32'(cpu_reset), 32'd1);
        chk("cpurst_ce",    32'(cpu_ce),    32'd1);
        chk("cpurst_ready", 32'(cmd_ready), 32'd0);
        chk("cpurst_cnt",   cycle_count,    32'd0);
        tick();
        chk("cpurst_after_state", 32'(state),     32'd0);
        chk("cpurst_after_cnt",   cycle_count,    32'd0);
        chk("cpurst_after_rst",   32'(cpu_reset), 32'd0);
        pc = 15'h000F;
        cmd(3'd1, 2'd0, 16'd0);
        tick(); pc = 15'h0010; #1;
        chk("bp_kept_ce", 32'(cpu_ce), 32'd0);
        tick();
        chk("bp_kept_state", 32'(state),      32'd0);
        chk("bp_kept_hit",   32'(bp_hit),     32'd1);
        chk("bp_kept_idx",   32'(bp_hit_idx), 32'd1);
        chk("bp_kept_cnt",   cycle_count,     32'd1);

        // stepping
        pc = 15'h0020;
        cmd(3'd3, 2'd0, 16'd3);
        chk("step_state", 32'(state),      32'd2);
        chk("step_left3", 32'(steps_left), 32'd3);
        chk("step_ce",    32'(cpu_ce),     32'd1);
        chk("step_bphit", 32'(bp_hit),     32'd0);
        tick();
        chk("step_left2", 32'(steps_left), 32'd2);
        tick();
        chk("step_left1", 32'(steps_left), 32'd1);
        tick();
        chk("step_left0", 32'(steps_left), 32'd0);
        chk("step_done",  32'(state),      32'd0);
        chk("step_cnt",   cycle_count,     32'd4);
        chk("step_ce0",   32'(cpu_ce),     32'd0);
        cmd(3'd3, 2'd0, 16'd0);
        chk("step0_state", 32'(state),      32'd2);
        chk("step0_left",  32'(steps_left), 32'd1);
        tick();
        chk("step0_done",  32'(state),      32'd0);
        chk("step0_cnt",   cycle_count,     32'd5);

        // two breakpoints on the same address hit while stepping
        cmd(3'd4, 2'd0, 16'h0005);
        cmd(3'd4, 2'd2, 16'h0005);
        pc = 15'h0030;
        cmd(3'd3, 2'd0, 16'd2);
        tick(); pc = 15'h0005; #1;
        chk("prio_left_pre", 32'(steps_left), 32'd1);
        chk("prio_ce",       32'(cpu_ce),     32'd0);
        tick();
        chk("prio_state", 32'(state),      32'd0);
        chk("prio_hit",   32'(bp_hit),     32'd1);
        chk("prio_idx",   32'(bp_hit_idx), 32'd0);
        chk("prio_left",  32'(steps_left), 32'd1);
        chk("prio_cnt",   cycle_count,     32'd6);

        // HALT accepted alongside a match; index 0 cleared so index 2 reports
        cmd(3'd5, 2'd0, 16'd0);
        pc = 15'h0040;
        cmd(3'd1, 2'd0, 16'd0);
        tick(); pc = 15'h0005;
        cmd(3'd2, 2'd0, 16'd0);
        chk("haltmatch_state", 32'(state),      32'd0);
        chk("haltmatch_hit",   32'(bp_hit),     32'd1);
        chk("haltmatch_idx",   32'(bp_hit_idx), 32'd2);
        chk("haltmatch_cnt",   cycle_count,     32'd7);

        // counter wrap and clear while running
        cmd(3'd7, 2'd0, 16'd0);
        chk("clr_halted", cycle_count, 32'd0);
        pc = 15'h0040;
        cmd(3'd1, 2'd0, 16'd0);
        repeat (17) tick();
        chk("wrap_cnt32", cycle_count, 32'd17);
        chk("wrap_cnt4",  32'(cycle_count4), 32'd1);
        cmd(3'd7, 2'd0, 16'd0);
        chk("clr_run_cnt",  cycle_count, 32'd0);
        chk("clr_run_cnt4", 32'(cycle_count4), 32'd0);
        tick();
        chk("clr_run_inc", cycle_count, 32'd1);

        // reset abandons a step in progress
        cmd(3'd3, 2'd0, 16'd5);
        chk("midstep_state", 32'(state), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("midrst_state", 32'(state),      32'd0);
        chk("midrst_steps", 32'(steps_left), 32'd0);
        chk("midrst_cnt",   cycle_count,     32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
